pe_mc: RTL and testbench
========================

# pe_mc

Multi-filter, strided successor to the single-filter row-stationary PE. Three scratchpads hold filter taps, activations and partial sums. One MAC per cycle computes the 1D convolution of up to `maxFilt` filters over one activation row, at a programmable stride. Results drain over a valid/ready psum interface, with each result added to the upstream psum. It sits in the PE array between the vertical psum neighbours, under cluster control.

## Interface
- `dataSize`, 8: signed width of weights and activations.
- `wSpadNReg`, 16: weight scratchpad depth, holding all filters.
- `aSpadNReg`, 32: activation scratchpad depth.
- `pSpadNReg`, 32: psum scratchpad depth.
- `maxFilt`, 4: maximum number of filters.
- `accWidth`, 2*dataSize+4: signed psum width.

- `clk` in 1: the single clock.
- `nrst` in 1: reset, synchronous, active-low.
- `weights_i` in dataSize: signed weight stream.
- `acts_i` in dataSize: signed activation stream.
- `ctrl_loadw` in 1: writes one weight per cycle.
- `ctrl_loada` in 1: writes one activation per cycle.
- `ctrl_wcount` in 8: taps per filter.
- `ctrl_acount` in 8: activations in the row.
- `ctrl_nfilt` in $clog2(maxFilt)+1: filter count; 0 is treated as 1.
- `ctrl_stride` in 2: stride; 0 is treated as 1.
- `ctrl_start` in 1: starts computation.
- `flag_busy` out 1: high in any state other than IDLE.
- `flag_done` out 1: one-cycle pulse at end of compute.
- `flag_err` out 1: one-cycle pulse when a start is rejected.
- `psum_i` in accWidth: signed upstream psum.
- `psum_i_valid` in 1: upstream psum valid.
- `psum_i_ready` out 1: upstream psum accepted.
- `psum_o` out accWidth: signed result, `pspad[rptr] + psum_i`.
- `psum_o_valid` out 1: result valid.
- `psum_o_ready` in 1: downstream ready.

## Operation
- States: IDLE, LOADW, LOADA, COMPUTE, DRAIN.
- IDLE → LOADW when `ctrl_loadw`=1. `ctrl_loadw` has priority if both load strobes are high.
- IDLE → LOADA when `ctrl_loada`=1.
- Load pointer behaviour:
  - The pointer clears on entering a load state.
  - Every cycle the strobe is high writes `spad[ptr]` and increments `ptr`.
  - The load state returns to IDLE on the cycle the strobe is low.
  - Writes past the scratchpad depth are dropped; the pointer saturates.
- Weight layout is filter-major: `w[f*wcount+k]`.
- Derived quantities:
  - `nPos = (acount-wcount)/stride + 1`, using integer division.
  - `nOut = nPos*nfilt`.
- IDLE → COMPUTE on `ctrl_start` only if all of these hold:
  - `wcount` ≥ 1;
  - `acount` ≥ `wcount`;
  - `acount` ≤ aSpadNReg;
  - `nfilt` ≤ maxFilt;
  - `nfilt*wcount` ≤ wSpadNReg;
  - `nOut` ≤ pSpadNReg.
- Otherwise the start is rejected: pulse `flag_err` and stay in IDLE.
- `ctrl_start` and load strobes are ignored outside IDLE.
- COMPUTE loop order: position `o` outer, filter `f` middle, tap `k` inner.
  - Each cycle: `acc += w[f*wcount+k] * a[o*stride+k]`.
  - `acc` clears at `k`=0.
  - At `k`=wcount-1, the result is written to `pspad[o*nfilt+f]`.
- COMPUTE → DRAIN after `nOut*wcount` cycles. `flag_done` pulses on the first DRAIN cycle.
- DRAIN handshake, all combinational:
  - `psum_o_valid = psum_i_valid`;
  - `psum_i_ready = psum_o_ready`;
  - `psum_o = pspad[rptr] + psum_i`.
- In DRAIN, a transfer occurs when both valid and ready are high, and `rptr` increments. After transfer `nOut`-1 the block goes to IDLE.
- Outside DRAIN: `psum_o_valid`=0, `psum_i_ready`=0, `psum_o`=0.
- Arithmetic:
  - The product is 2*dataSize bits signed.
  - `acc` is accWidth bits with sign extension; it cannot overflow within the legal tap counts.
  - The DRAIN add follows the Configuration section.
- Weights and activations persist across runs, so a new start without reload reuses them.

## Timing
- Reset (`nrst`=0 at an edge):
  - state becomes IDLE;
  - all pointers and `acc` clear;
  - all outputs are 0 from the next edge;
  - scratchpad contents are not reset.
- Reset mid-COMPUTE or mid-DRAIN aborts the run. No further `psum_o_valid` is raised.
- `ctrl_start` sampled at edge N:
  - COMPUTE runs from edge N+1;
  - `flag_done`=1 during cycle N+1+`nOut*wcount`.
- `flag_err` is high for the one cycle after the rejecting edge.
- DRAIN has zero latency: `psum_o` follows `psum_i` combinationally. Throughput is one result per cycle with no backpressure.

## Configuration
- Macro: `PE_SATURATE_EN`.
- Defined: the DRAIN add saturates to [-2^(accWidth-1), 2^(accWidth-1)-1].
- Undefined: the DRAIN add wraps modulo 2^accWidth (two's complement).

## Test plan
- Basic run:
  - Stimulus: nfilt=1, wcount=3, acount=16, stride=1; w={1,2,3}; a=0..15; `psum_i`=1 with valid=1; ready=1.
  - Required: 14 outputs `6o+9` (9, 15, …, 87); `flag_done` 43 cycles after the start edge.
- Multi-filter with stride:
  - Stimulus: nfilt=2, wcount=2, stride=2; w={1,1,1,-1}; a=0..7; `psum_i`=0.
  - Required: outputs 1, -1, 5, -1, 9, -1, 13, -1.
- Backpressure: rerun the basic case with `psum_o_ready` toggling every cycle.
  - Required: the same 14 values in order, with none lost or duplicated.
  - Required: `psum_i_ready` equals `psum_o_ready` each DRAIN cycle.
- Overflow:
  - Stimulus: wcount=16, acount=16; all weights and activations 127; `psum_i`=524287.
  - With `PE_SATURATE_EN`: output 524287.
  - Without it: output -266225.
- Rejected start:
  - Stimulus: wcount=5, acount=4, then start.
  - Required: `flag_err`=1 for one cycle; `flag_busy` stays 0; no `psum_o_valid`.
- Reset mid-run: `nrst`=0 for one cycle mid-COMPUTE.
  - Required: all outputs 0 the next cycle.
  - Required: a reload followed by a basic rerun passes.

Source files
------------

// File: rtl/pe_mc_if.sv
// Psum handshake bus between vertically adjacent PEs: upstream psum in, summed result out.
interface pe_mc_if #(parameter int accWidth = 20);
    logic signed [accWidth-1:0] psum_i;
    logic                       psum_i_valid;
    logic                       psum_i_ready;
    logic signed [accWidth-1:0] psum_o;
    logic                       psum_o_valid;
    logic                       psum_o_ready;

    modport slave (input psum_i, psum_i_valid, psum_o_ready,
                   output psum_i_ready, psum_o, psum_o_valid);
    modport master (output psum_i, psum_i_valid, psum_o_ready,
                    input psum_i_ready, psum_o, psum_o_valid);
endinterface

// File: rtl/pe_mc.sv
// Multi-filter strided row-stationary PE: weight/act/psum scratchpads, one MAC per cycle, psum drain.
// Optional macro PE_SATURATE_EN makes the drain add saturate instead of wrap.
module pe_mc #(
    parameter int dataSize  = 8,
    parameter int wSpadNReg = 16,
    parameter int aSpadNReg = 32,
    parameter int pSpadNReg = 32,
    parameter int maxFilt   = 4,
    parameter int accWidth  = 2*dataSize+4
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic signed [dataSize-1:0]    weights_i,
    input  logic signed [dataSize-1:0]    acts_i,
    input  logic                          ctrl_loadw,
    input  logic                          ctrl_loada,
    input  logic [7:0]                    ctrl_wcount,
    input  logic [7:0]                    ctrl_acount,
    input  logic [$clog2(maxFilt):0]      ctrl_nfilt,
    input  logic [1:0]                    ctrl_stride,
    input  logic                          ctrl_start,
    output logic                          flag_busy,
    output logic                          flag_done,
    output logic                          flag_err,
    pe_mc_if.slave                        bus
);
    localparam int WAW = $clog2(wSpadNReg);
    localparam int AAW = $clog2(aSpadNReg);
    localparam int PAW = $clog2(pSpadNReg);
    localparam logic [15:0] W_DEPTH = 16'(wSpadNReg);
    localparam logic [15:0] A_DEPTH = 16'(aSpadNReg);
    localparam logic [15:0] P_DEPTH = 16'(pSpadNReg);
    localparam logic [15:0] F_MAX   = 16'(maxFilt);

    typedef enum logic [2:0] {IDLE, LOADW, LOADA, COMPUTE, DRAIN} state_t;
    state_t state, state_n;

    logic signed [dataSize-1:0] wspad [wSpadNReg];
    logic signed [dataSize-1:0] aspad [aSpadNReg];
    logic signed [accWidth-1:0] pspad [pSpadNReg];

    logic [15:0]          wptr, aptr, pidx, rptr, nout_r;
    logic [7:0]           wc_r, nf_r, k, f;
    logic [1:0]           st_r;
    logic [WAW-1:0]       wbase;
    logic [AAW-1:0]       abase;
    logic signed [accWidth-1:0] acc_p1;

    function automatic logic signed [accWidth-1:0] drain_add(
        input logic signed [accWidth-1:0] a, input logic signed [accWidth-1:0] b);
`ifdef PE_SATURATE_EN
        logic signed [accWidth:0] s;
        s = {a[accWidth-1], a} + {b[accWidth-1], b};
        if (s[accWidth] != s[accWidth-1])
            drain_add = s[accWidth] ? {1'b1, {(accWidth-1){1'b0}}} : {1'b0, {(accWidth-1){1'b1}}};
        else
            drain_add = s[accWidth-1:0];
`else
        drain_add = a + b;
`endif
    endfunction

    // Start qualification from the live control inputs
    logic [7:0]  nf_e;
    logic [1:0]  st_e;
    logic [15:0] npos, nout, wtot;
    logic        start_ok;
    always_comb begin
        nf_e     = (ctrl_nfilt == '0) ? 8'd1 : 8'(ctrl_nfilt);
        st_e     = (ctrl_stride == 2'd0) ? 2'd1 : ctrl_stride;
        npos     = 16'((ctrl_acount - ctrl_wcount) / {6'd0, st_e}) + 16'd1;
        nout     = npos * {8'd0, nf_e};
        wtot     = {8'd0, nf_e} * {8'd0, ctrl_wcount};
        start_ok = (ctrl_wcount != 8'd0) && (ctrl_acount >= ctrl_wcount)
                && ({8'd0, ctrl_acount} <= A_DEPTH) && ({8'd0, nf_e} <= F_MAX)
                && (wtot <= W_DEPTH) && (nout <= P_DEPTH);
    end

    logic [WAW-1:0]               waddr;
    logic [AAW-1:0]               aaddr;
    logic signed [dataSize-1:0]   wv, av;
    logic signed [2*dataSize-1:0] prod;
    logic signed [accWidth-1:0]   acc_n;
    logic last_tap, last_filt, last_out, xfer, last_xfer;
    always_comb begin
        waddr     = wbase + k[WAW-1:0];
        aaddr     = abase + k[AAW-1:0];
        wv        = wspad[waddr];
        av        = aspad[aaddr];
        prod      = {{dataSize{wv[dataSize-1]}}, wv} * {{dataSize{av[dataSize-1]}}, av};
        acc_n     = (k == 8'd0) ? {{(accWidth-2*dataSize){prod[2*dataSize-1]}}, prod}
                                : acc_p1 + {{(accWidth-2*dataSize){prod[2*dataSize-1]}}, prod};
        last_tap  = (k == wc_r - 8'd1);
        last_filt = (f == nf_r - 8'd1);
        last_out  = (pidx == nout_r - 16'd1);
        xfer      = (state == DRAIN) && bus.psum_i_valid && bus.psum_o_ready;
        last_xfer = xfer && (rptr == nout_r - 16'd1);
    end

    logic done_n, err_n;
    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (ctrl_loadw)      state_n = LOADW;
                else if (ctrl_loada) state_n = LOADA;
                else if (ctrl_start) begin
                    if (start_ok) state_n = COMPUTE;
                    else          err_n   = 1'b1;
                end
            end
            LOADW:   if (!ctrl_loadw) state_n = IDLE;
            LOADA:   if (!ctrl_loada) state_n = IDLE;
            COMPUTE: if (last_tap && last_filt && last_out) begin
                state_n = DRAIN;
                done_n  = 1'b1;
            end
            DRAIN:   if (last_xfer) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= IDLE;
            flag_done <= 1'b0;
            flag_err  <= 1'b0;
        end else begin
            state     <= state_n;
            flag_done <= done_n;
            flag_err  <= err_n;
        end
    end

    // Pointers, loop counters and accumulator
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wptr <= '0; aptr <= '0; pidx <= '0; rptr <= '0; nout_r <= '0;
            wc_r <= '0; nf_r <= '0; st_r <= '0; k <= '0; f <= '0;
            wbase <= '0; abase <= '0; acc_p1 <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ctrl_loadw)      wptr <= 16'd1;
                    else if (ctrl_loada) aptr <= 16'd1;
                    else if (ctrl_start && start_ok) begin
                        wc_r <= ctrl_wcount; nf_r <= nf_e; st_r <= st_e; nout_r <= nout;
                        k <= '0; f <= '0; wbase <= '0; abase <= '0; pidx <= '0; rptr <= '0;
                    end
                end
                LOADW: if (ctrl_loadw && wptr < W_DEPTH) wptr <= wptr + 16'd1;
                LOADA: if (ctrl_loada && aptr < A_DEPTH) aptr <= aptr + 16'd1;
                COMPUTE: begin
                    acc_p1 <= acc_n;
                    if (last_tap) begin
                        k    <= '0;
                        pidx <= pidx + 16'd1;
                        if (last_filt) begin
                            f     <= '0;
                            wbase <= '0;
                            abase <= abase + AAW'(st_r);
                        end else begin
                            f     <= f + 8'd1;
                            wbase <= wbase + wc_r[WAW-1:0];
                        end
                    end else begin
                        k <= k + 8'd1;
                    end
                end
                DRAIN: if (xfer) rptr <= rptr + 16'd1;
                default: ;
            endcase
        end
    end

    // Scratchpad storage is never reset; an IDLE strobe cycle writes entry 0
    logic w_we, a_we, p_we;
    always_comb begin
        w_we = nrst && ctrl_loadw && ((state == IDLE) || (state == LOADW && wptr < W_DEPTH));
        a_we = nrst && ctrl_loada && ((state == IDLE && !ctrl_loadw) || (state == LOADA && aptr < A_DEPTH));
        p_we = nrst && (state == COMPUTE) && last_tap;
    end

    always_ff @(posedge clk) begin
        if (w_we) wspad[(state == IDLE) ? '0 : wptr[WAW-1:0]] <= weights_i;
        if (a_we) aspad[(state == IDLE) ? '0 : aptr[AAW-1:0]] <= acts_i;
        if (p_we) pspad[pidx[PAW-1:0]] <= acc_n;
    end

    always_comb begin
        bus.psum_o       = '0;
        bus.psum_o_valid = 1'b0;
        bus.psum_i_ready = 1'b0;
        if (state == DRAIN) begin
            bus.psum_o       = drain_add(pspad[rptr[PAW-1:0]], bus.psum_i);
            bus.psum_o_valid = bus.psum_i_valid;
            bus.psum_i_ready = bus.psum_o_ready;
        end
    end

    assign flag_busy = (state != IDLE);
endmodule

// File: tb/tb_pe_mc.sv
// Directed and randomized bench for pe_mc, checked against a loop-level convolution model.
module tb_pe_mc;
    localparam int ACC = 20;

    logic              clk = 1'b0;
    logic              nrst;
    logic signed [7:0] weights_i, acts_i;
    logic              ctrl_loadw, ctrl_loada, ctrl_start;
    logic [7:0]        ctrl_wcount, ctrl_acount;
    logic [2:0]        ctrl_nfilt;
    logic [1:0]        ctrl_stride;
    logic              flag_busy, flag_done, flag_err;

    int checks = 0;
    int errors = 0;
    int wv [16];
    int av [32];
    int expq [$];

    always #5 clk = ~clk;

    pe_mc_if #(.accWidth(ACC)) bus ();

    pe_mc dut (
        .clk(clk), .nrst(nrst), .weights_i(weights_i), .acts_i(acts_i),
        .ctrl_loadw(ctrl_loadw), .ctrl_loada(ctrl_loada),
        .ctrl_wcount(ctrl_wcount), .ctrl_acount(ctrl_acount),
        .ctrl_nfilt(ctrl_nfilt), .ctrl_stride(ctrl_stride), .ctrl_start(ctrl_start),
        .flag_busy(flag_busy), .flag_done(flag_done), .flag_err(flag_err),
        .bus(bus)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int fold(input longint s);
`ifdef PE_SATURATE_EN
        if (s > 524287) return 524287;
        if (s < -524288) return -524288;
        return int'(s);
`else
        longint m;
        m = s & 64'hFFFFF;
        if (m >= 524288) m -= 1048576;
        return int'(m);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input int n);
        for (int i = 0; i < n; i++) begin
            weights_i = 8'(wv[i]); ctrl_loadw = 1'b1; step();
        end
        ctrl_loadw = 1'b0; step();
        check("loadw_back_idle", flag_busy, 0);
    endtask

    task automatic load_a(input int n);
        for (int i = 0; i < n; i++) begin
            acts_i = 8'(av[i]); ctrl_loada = 1'b1; step();
        end
        ctrl_loada = 1'b0; step();
        check("loada_back_idle", flag_busy, 0);
    endtask

    // Reference: every output position, every filter, dot product over the taps
    task automatic model(input int nf, input int wc, input int ac, input int st);
        int npos, s;
        expq.delete();
        npos = (ac - wc) / st + 1;
        for (int o = 0; o < npos; o++)
            for (int fi = 0; fi < nf; fi++) begin
                s = 0;
                for (int kk = 0; kk < wc; kk++) s += wv[fi*wc + kk] * av[o*st + kk];
                expq.push_back(s);
            end
    endtask

    task automatic start_run(input int nfd, input int nf, input int wc, input int ac,
                             input int std, input int st);
        int lat;
        model(nf, wc, ac, st);
        ctrl_nfilt = 3'(nfd); ctrl_wcount = 8'(wc); ctrl_acount = 8'(ac); ctrl_stride = 2'(std);
        ctrl_start = 1'b1; step(); ctrl_start = 1'b0;
        check("start_busy", flag_busy, 1);
        lat = 0;
        while (flag_done !== 1'b1 && lat < 4000) begin step(); lat++; end
        check("done_latency", lat + 1, expq.size() * wc + 1);
    endtask

    // mode 0: always valid/ready, 1: ready toggles, 2: random valid/ready/psum
    task automatic drain(input int mode, input int pin);
        int idx, cyc, v, r, pv;
        idx = 0; cyc = 0;
        while (idx < expq.size() && cyc < 2000) begin
            v  = (mode == 2) ? int'($urandom_range(0, 1)) : 1;
            r  = (mode == 0) ? 1 : (mode == 1) ? ((cyc % 2 == 0) ? 1 : 0) : int'($urandom_range(0, 1));
            pv = (mode == 2) ? int'($urandom_range(0, 1048575)) - 524288 : pin;
            bus.psum_i_valid = v[0]; bus.psum_o_ready = r[0]; bus.psum_i = 20'(pv);
            #1;
            check("in_ready_follows", bus.psum_i_ready, r);
            check("out_valid_follows", bus.psum_o_valid, v);
            if (v == 1 && r == 1) begin
                check($sformatf("psum_o[%0d]", idx), bus.psum_o, fold(longint'(expq[idx]) + pv));
                idx++;
            end
            @(posedge clk); #1; cyc++;
            if (cyc == 1) check("done_one_cycle", flag_done, 0);
        end
        bus.psum_i_valid = 1'b0; bus.psum_o_ready = 1'b0; bus.psum_i = '0;
        check("drain_count", idx, expq.size());
        check("drain_exit_idle", flag_busy, 0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, flag_busy, 0);
        check({tag, "_done"}, flag_done, 0);
        check({tag, "_err"}, flag_err, 0);
        check({tag, "_ovalid"}, bus.psum_o_valid, 0);
        check({tag, "_iready"}, bus.psum_i_ready, 0);
        check({tag, "_psum"}, bus.psum_o, 0);
    endtask

    task automatic basic_vectors();
        wv[0] = 1; wv[1] = 2; wv[2] = 3;
        for (int i = 0; i < 16; i++) av[i] = i;
    endtask

    initial begin
        int seen, nf, wc, ac, st, npos;
        int rej [3][3];
        nrst = 1'b0; weights_i = '0; acts_i = '0; ctrl_loadw = 1'b0; ctrl_loada = 1'b0;
        ctrl_wcount = '0; ctrl_acount = '0; ctrl_nfilt = '0; ctrl_stride = '0; ctrl_start = 1'b0;
        bus.psum_i = '0; bus.psum_i_valid = 1'b0; bus.psum_o_ready = 1'b0;
        step(); step();
        nrst = 1'b1;
        check_quiet("reset");

        // Basic run, with the 6o+9 answer written out directly
        basic_vectors();
        load_w(3); load_a(16);
        start_run(1, 1, 3, 16, 1, 1);
        for (int o = 0; o < 14; o++) check("basic_model_const", expq[o] + 1, 6*o + 9);
        drain(0, 1);

        // Multi-filter, stride 2
        wv[0] = 1; wv[1] = 1; wv[2] = 1; wv[3] = -1;
        for (int i = 0; i < 8; i++) av[i] = i;
        load_w(4); load_a(8);
        start_run(2, 2, 2, 8, 2, 2);
        begin
            int want [8] = '{1, -1, 5, -1, 9, -1, 13, -1};
            for (int i = 0; i < 8; i++) check("mf_model_const", expq[i], want[i]);
        end
        drain(0, 0);

        // Backpressure: activations persist, only weights reloaded
        basic_vectors();
        load_w(3);
        start_run(1, 1, 3, 16, 1, 1);
        drain(1, 1);

        // Accumulator/drain overflow
        for (int i = 0; i < 16; i++) begin wv[i] = 127; av[i] = 127; end
        load_w(16); load_a(16);
        start_run(1, 1, 16, 16, 1, 1);
        bus.psum_i = 20'(524287); bus.psum_i_valid = 1'b1; bus.psum_o_ready = 1'b1;
        #1;
`ifdef PE_SATURATE_EN
        check("overflow", bus.psum_o, 524287);
`else
        check("overflow", bus.psum_o, -266225);
`endif
        step();
        bus.psum_i_valid = 1'b0; bus.psum_o_ready = 1'b0; bus.psum_i = '0;
        check("overflow_idle", flag_busy, 0);

        // Rejected starts: acount<wcount, too many weights, too many outputs
        rej[0] = '{1, 5, 4}; rej[1] = '{4, 5, 8}; rej[2] = '{2, 1, 32};
        for (int j = 0; j < 3; j++) begin
            ctrl_nfilt = 3'(rej[j][0]); ctrl_wcount = 8'(rej[j][1]); ctrl_acount = 8'(rej[j][2]);
            ctrl_stride = 2'd1; bus.psum_i_valid = 1'b1; bus.psum_o_ready = 1'b1;
            ctrl_start = 1'b1; step(); ctrl_start = 1'b0;
            check("reject_err", flag_err, 1);
            check("reject_busy", flag_busy, 0);
            check("reject_ovalid", bus.psum_o_valid, 0);
            step();
            check("reject_err_pulse", flag_err, 0);
            check("reject_busy2", flag_busy, 0);
        end
        bus.psum_i_valid = 1'b0; bus.psum_o_ready = 1'b0;

        // Reset in the middle of COMPUTE
        basic_vectors();
        load_w(3); load_a(16);
        ctrl_nfilt = 3'd1; ctrl_wcount = 8'd3; ctrl_acount = 8'd16; ctrl_stride = 2'd1;
        ctrl_start = 1'b1; step(); ctrl_start = 1'b0;
        repeat (10) step();
        check("midrun_busy", flag_busy, 1);
        nrst = 1'b0; step(); nrst = 1'b1;
        check_quiet("midrun_reset");
        bus.psum_i_valid = 1'b1; bus.psum_o_ready = 1'b1;
        seen = 0;
        repeat (60) begin step(); if (bus.psum_o_valid === 1'b1) seen++; end
        check("post_reset_no_valid", seen, 0);
        bus.psum_i_valid = 1'b0; bus.psum_o_ready = 1'b0;
        load_w(3); load_a(16);
        start_run(1, 1, 3, 16, 1, 1);
        drain(0, 1);

        // Randomized configurations, zero encodings for nfilt/stride included
        for (int it = 0; it < 6; it++) begin
            do begin
                nf = int'($urandom_range(1, 4));
                wc = int'($urandom_range(1, 4));
                st = int'($urandom_range(1, 3));
                ac = int'($urandom_range(wc, 20));
                npos = (ac - wc) / st + 1;
            end while (nf * wc > 16 || npos * nf > 32);
            for (int i = 0; i < 16; i++) wv[i] = int'($urandom_range(0, 255)) - 128;
            for (int i = 0; i < 32; i++) av[i] = int'($urandom_range(0, 255)) - 128;
            load_w(nf * wc); load_a(ac);
            start_run((nf == 1 && it % 2 == 0) ? 0 : nf, nf, wc, ac,
                      (st == 1 && it % 2 == 1) ? 0 : st, st);
            drain(2, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
